// File: rtl/local_network_interface_if.sv
// Core/router-facing signal bundle for the local network interface.
// slave = the NI itself, master = whatever drives it (core + router model).
interface local_network_interface_if #(
    parameter int DATA_W = 16
);
    logic              tx_req_i;
    logic [DATA_W-1:0] tx_dest_i;
    logic              tx_ack_o;
    logic              tx_pld_valid_i;
    logic [DATA_W-1:0] tx_pld_i;
    logic              tx_pld_ready_o;
    logic [DATA_W-1:0] ni_data_o;
    logic              ni_valid_o;
    logic              ni_credit_i;
    logic [DATA_W-1:0] ni_data_i;
    logic              ni_valid_i;
    logic              ni_credit_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              rx_head_o;
    logic              rx_ready_i;
    logic              err_overflow_o;
    logic [15:0]       stat_tx_pkts_o;
    logic [15:0]       stat_rx_pkts_o;

    modport slave (
        input  tx_req_i, tx_dest_i, tx_pld_valid_i, tx_pld_i, ni_credit_i,
               ni_data_i, ni_valid_i, rx_ready_i,
        output tx_ack_o, tx_pld_ready_o, ni_data_o, ni_valid_o, ni_credit_o,
               rx_data_o, rx_valid_o, rx_head_o, err_overflow_o,
               stat_tx_pkts_o, stat_rx_pkts_o
    );

    modport master (
        output tx_req_i, tx_dest_i, tx_pld_valid_i, tx_pld_i, ni_credit_i,
               ni_data_i, ni_valid_i, rx_ready_i,
        input  tx_ack_o, tx_pld_ready_o, ni_data_o, ni_valid_o, ni_credit_o,
               rx_data_o, rx_valid_o, rx_head_o, err_overflow_o,
               stat_tx_pkts_o, stat_rx_pkts_o
    );
endinterface

// File: rtl/local_network_interface.sv
// Local-port network interface: credit-controlled TX packetizer plus RX ejection FIFO.
// Optional packet statistics counters are built when NI_STATS_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for a core request; tx_ack_o pulses on acceptance
// S_HEAD | destination latched, header flit waits for a credit
// S_BODY | streaming PKT_LEN-1 body words, one per valid word with a credit
module local_network_interface #(
    parameter int DATA_W   = 16,
    parameter int PKT_LEN  = 4,
    parameter int CREDITS  = 8,
    parameter int EJ_DEPTH = 8
) (
    input logic                       clk,
    input logic                       reset,
    local_network_interface_if.slave  bus
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int BW = $clog2(PKT_LEN);
    localparam int PW = $clog2(EJ_DEPTH);
    localparam int FW = $clog2(EJ_DEPTH + 1);

    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [BW-1:0] LAST_BODY = BW'(PKT_LEN - 2);
    localparam logic [BW-1:0] LAST_IDX  = BW'(PKT_LEN - 1);
    localparam logic [FW-1:0] FIFO_FULL = FW'(EJ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY
    } tx_state_t;

    tx_state_t         state, state_nxt;
    logic [CW-1:0]     credit_cnt;
    logic [BW-1:0]     body_cnt;
    logic [DATA_W-1:0] dest_q;
    logic [DATA_W-1:0] ni_data_q;
    logic              ni_valid_q;
    logic              can_send;
    logic              tx_ack;
    logic              pld_ready;
    logic              send_head;
    logic              send_body;
    logic              send;

    assign can_send = (credit_cnt != '0);
    assign send     = send_head | send_body;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_ack    = 1'b0;
        pld_ready = 1'b0;
        send_head = 1'b0;
        send_body = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.tx_req_i) begin
                    tx_ack    = 1'b1;
                    state_nxt = S_HEAD;
                end
            end
            S_HEAD: begin
                if (can_send) begin
                    send_head = 1'b1;
                    state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                if (bus.tx_pld_valid_i && can_send) begin
                    send_body = 1'b1;
                    pld_ready = 1'b1;
                    if (body_cnt == LAST_BODY) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_q     <= '0;
            body_cnt   <= '0;
            ni_data_q  <= '0;
            ni_valid_q <= 1'b0;
        end else begin
            if (tx_ack) dest_q <= bus.tx_dest_i;
            if (send_head)      body_cnt <= '0;
            else if (send_body) body_cnt <= body_cnt + 1'b1;
            // data holds its last flit between sends; only valid drops
            if (send_head)      ni_data_q <= dest_q;
            else if (send_body) ni_data_q <= bus.tx_pld_i;
            ni_valid_q <= send;
        end
    end

    // a credit arriving together with a send cancels out; at the ceiling extra credits vanish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_cnt <= CRED_MAX;
        end else if (send && !bus.ni_credit_i) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (!send && bus.ni_credit_i && (credit_cnt != CRED_MAX)) begin
            credit_cnt <= credit_cnt + 1'b1;
        end
    end

    assign bus.tx_ack_o       = tx_ack;
    assign bus.tx_pld_ready_o = pld_ready;
    assign bus.ni_data_o      = ni_data_q;
    assign bus.ni_valid_o     = ni_valid_q;

    logic [DATA_W-1:0] mem [EJ_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [FW-1:0]     fifo_cnt;
    logic [BW-1:0]     rx_idx;
    logic              fifo_full;
    logic              rx_valid;
    logic              pop;
    logic              push;
    logic              credit_q;
    logic              overflow_q;

    assign fifo_full = (fifo_cnt == FIFO_FULL);
    assign rx_valid  = (fifo_cnt != '0);
    assign pop       = rx_valid & bus.rx_ready_i;
    // a pop frees the slot in the same cycle, so a write at full is legal then
    assign push      = bus.ni_valid_i & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.ni_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            rx_idx     <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rx_idx <= (rx_idx == LAST_IDX) ? '0 : rx_idx + 1'b1;
            end
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
            credit_q <= pop;
            if (bus.ni_valid_i && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.rx_valid_o     = rx_valid;
    assign bus.rx_data_o      = rx_valid ? mem[rd_ptr] : '0;
    assign bus.rx_head_o      = rx_valid && (rx_idx == '0);
    assign bus.ni_credit_o    = credit_q;
    assign bus.err_overflow_o = overflow_q;

`ifdef NI_STATS_EN
    logic [15:0] stat_tx_q;
    logic [15:0] stat_rx_q;
    logic        tx_pkt_done;
    logic        rx_pkt_done;

    assign tx_pkt_done = send_body && (body_cnt == LAST_BODY);
    assign rx_pkt_done = pop && (rx_idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_tx_q <= '0;
            stat_rx_q <= '0;
        end else begin
            if (tx_pkt_done) stat_tx_q <= stat_tx_q + 16'd1;
            if (rx_pkt_done) stat_rx_q <= stat_rx_q + 16'd1;
        end
    end

    assign bus.stat_tx_pkts_o = stat_tx_q;
    assign bus.stat_rx_pkts_o = stat_rx_q;
`else
    assign bus.stat_tx_pkts_o = 16'd0;
    assign bus.stat_rx_pkts_o = 16'd0;
`endif

endmodule

// File: tb/tb_local_network_interface.sv
// Directed, table-driven bench for local_network_interface (default parameters:
// 16-bit flits, 4-flit packets, 8 credits, 8-deep ejection FIFO).
module tb_local_network_interface;

    logic clk;
    logic reset;

    local_network_interface_if #(.DATA_W(16)) bus ();

    local_network_interface #(
        .DATA_W(16), .PKT_LEN(4), .CREDITS(8), .EJ_DEPTH(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef NI_STATS_EN
    localparam logic [15:0] EXP_STAT_TX = 16'd2;
    localparam logic [15:0] EXP_STAT_RX = 16'd1;
`else
    localparam logic [15:0] EXP_STAT_TX = 16'd0;
    localparam logic [15:0] EXP_STAT_RX = 16'd0;
`endif

    typedef struct {
        logic [15:0]       dest;
        logic [0:2][15:0]  w;
    } pkt_t;

    typedef struct {
        logic [15:0]       dest;
        logic [0:2][15:0]  w;
        logic [0:3][15:0]  e;
    } tx_vec_t;

    typedef struct {
        logic [15:0] data;
        logic        head;
    } rx_vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // cycle counter and output monitor, sampled mid-cycle
    int          cyc = 0;
    logic [15:0] flit_q[$];
    int          flit_cyc[$];
    int          ack_cnt  = 0;
    int          ack_cyc  = 0;
    int          cred_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.ni_valid_o) begin
            flit_q.push_back(bus.ni_data_o);
            flit_cyc.push_back(cyc);
        end
        if (bus.tx_ack_o) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (bus.ni_credit_o) cred_cnt++;
    end

    // core model: plays queued packets, abandons one in flight on reset
    pkt_t pkts[16];
    int   pkt_wr = 0;

    initial begin
        int   pkt_rd;
        int   k;
        pkt_t p;
        pkt_rd             = 0;
        bus.tx_req_i       = 1'b0;
        bus.tx_dest_i      = '0;
        bus.tx_pld_valid_i = 1'b0;
        bus.tx_pld_i       = '0;
        forever begin
            @(posedge clk); #1;
            if (pkt_rd < pkt_wr && !reset) begin
                p = pkts[pkt_rd];
                pkt_rd++;
                bus.tx_req_i  = 1'b1;
                bus.tx_dest_i = p.dest;
                do @(negedge clk); while (!bus.tx_ack_o && !reset);
                @(posedge clk); #1;
                bus.tx_req_i = 1'b0;
                if (!reset) begin
                    k = 0;
                    bus.tx_pld_valid_i = 1'b1;
                    bus.tx_pld_i       = p.w[0];
                    while (k < 3 && !reset) begin
                        @(negedge clk);
                        if (bus.tx_pld_ready_o) k++;
                        @(posedge clk); #1;
                        if (k < 3) bus.tx_pld_i = p.w[k];
                    end
                end
                bus.tx_pld_valid_i = 1'b0;
            end
        end
    end

    task automatic queue_pkt(input logic [15:0] dest, input logic [0:2][15:0] w);
        pkts[pkt_wr].dest = dest;
        pkts[pkt_wr].w    = w;
        pkt_wr++;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        tick();
        reset          = 1'b1;
        bus.ni_valid_i = 1'b0;
        bus.ni_credit_i = 1'b0;
        bus.rx_ready_i = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_flits(input int base, input int n, input int budget);
        int t;
        t = 0;
        while (flit_q.size() - base < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic push_rx(input logic [15:0] d);
        bus.ni_data_i  = d;
        bus.ni_valid_i = 1'b1;
        tick();
        bus.ni_valid_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_ack"},    32'(bus.tx_ack_o), 32'd0);
        chk({tag, "_pld_ready"}, 32'(bus.tx_pld_ready_o), 32'd0);
        chk({tag, "_ni_data"},   32'(bus.ni_data_o), 32'd0);
        chk({tag, "_ni_valid"},  32'(bus.ni_valid_o), 32'd0);
        chk({tag, "_ni_credit"}, 32'(bus.ni_credit_o), 32'd0);
        chk({tag, "_rx"},        32'({bus.rx_data_o, bus.rx_valid_o, bus.rx_head_o}), 32'd0);
        chk({tag, "_err"},       32'(bus.err_overflow_o), 32'd0);
        chk({tag, "_stats"},     {bus.stat_tx_pkts_o, bus.stat_rx_pkts_o}, 32'd0);
    endtask

    tx_vec_t tv[3];
    rx_vec_t rv[8];

    initial begin
        int fb, ab, cb;
        logic [15:0] last;

        tv[0] = '{dest: 16'h0203, w: {16'h00A1, 16'h00A2, 16'h00A3},
                  e: {16'h0203, 16'h00A1, 16'h00A2, 16'h00A3}};
        tv[1] = '{dest: 16'hFFFF, w: {16'h0000, 16'hFFFF, 16'h5A5A},
                  e: {16'hFFFF, 16'h0000, 16'hFFFF, 16'h5A5A}};
        tv[2] = '{dest: 16'h0000, w: {16'h1234, 16'h8001, 16'h0000},
                  e: {16'h0000, 16'h1234, 16'h8001, 16'h0000}};
        for (int i = 0; i < 8; i++) begin
            rv[i].data = 16'h0010 + 16'(i);
            rv[i].head = (i == 0 || i == 4);
        end

        reset           = 1'b1;
        bus.ni_valid_i  = 1'b0;
        bus.ni_data_i   = '0;
        bus.ni_credit_i = 1'b0;
        bus.rx_ready_i  = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        tick();
        reset = 1'b0;

        // single packets: data order, back-to-back flits, header latency, one ack
        for (int v = 0; v < 3; v++) begin
            do_reset();
            fb = flit_q.size();
            ab = ack_cnt;
            queue_pkt(tv[v].dest, tv[v].w);
            wait_flits(fb, 4, 40);
            repeat (5) tick();
            chk($sformatf("v%0d_nflits", v), 32'(flit_q.size() - fb), 32'd4);
            for (int i = 0; i < 4; i++)
                chk($sformatf("v%0d_flit%0d", v, i), 32'(flit_q[fb + i]), 32'(tv[v].e[i]));
            chk($sformatf("v%0d_span", v), 32'(flit_cyc[fb + 3] - flit_cyc[fb]), 32'd3);
            chk($sformatf("v%0d_hdr_lat", v), 32'(flit_cyc[fb] - ack_cyc), 32'd2);
            chk($sformatf("v%0d_acks", v), 32'(ack_cnt - ab), 32'd1);
        end

        // reset mid-body, then full credit budget must be back
        do_reset();
        fb = flit_q.size();
        queue_pkt(16'h0505, {16'h00B1, 16'h00B2, 16'h00B3});
        wait_flits(fb, 2, 40);
        tick();
        reset = 1'b1;
        #1;
        check_zero("midrst");
        repeat (2) tick();
        reset = 1'b0;
        fb = flit_q.size();
        queue_pkt(16'h0606, {16'h0061, 16'h0062, 16'h0063});
        queue_pkt(16'h0707, {16'h0071, 16'h0072, 16'h0073});
        wait_flits(fb, 8, 80);
        chk("midrst_nflits", 32'(flit_q.size() - fb), 32'd8);
        chk("midrst_hdr1",   32'(flit_q[fb]), 32'h0606);
        chk("midrst_hdr2",   32'(flit_q[fb + 4]), 32'h0707);

        // credit exhaustion with three packets queued and no credits returned
        do_reset();
        fb = flit_q.size();
        ab = ack_cnt;
        queue_pkt(16'h0101, {16'h0011, 16'h0012, 16'h0013});
        queue_pkt(16'h0202, {16'h0021, 16'h0022, 16'h0023});
        queue_pkt(16'h0303, {16'h0031, 16'h0032, 16'h0033});
        repeat (60) tick();
        chk("cred_nflits8",  32'(flit_q.size() - fb), 32'd8);
        chk("cred_pkt2_hdr", 32'(flit_q[fb + 4]), 32'h0202);
        chk("cred_pkt2_end", 32'(flit_q[fb + 7]), 32'h0023);
        bus.ni_credit_i = 1'b1;
        tick();
        bus.ni_credit_i = 1'b0;
        repeat (10) tick();
        chk("cred_nflits9",  32'(flit_q.size() - fb), 32'd9);
        chk("cred_pkt3_hdr", 32'(flit_q[fb + 8]), 32'h0303);

        // credit returned in the same cycle as a send at count 1
        bus.ni_credit_i = 1'b1;
        repeat (2) tick();
        bus.ni_credit_i = 1'b0;
        repeat (10) tick();
        chk("same_cyc_nflits", 32'(flit_q.size() - fb), 32'd11);
        chk("same_cyc_back2back", 32'(flit_cyc[fb + 10] - flit_cyc[fb + 9]), 32'd1);
        chk("same_cyc_data", 32'(flit_q[fb + 10]), 32'h0032);
        bus.ni_credit_i = 1'b1;
        tick();
        bus.ni_credit_i = 1'b0;
        repeat (10) tick();
        chk("cred_nflits12", 32'(flit_q.size() - fb), 32'd12);
        chk("cred_last",     32'(flit_q[fb + 11]), 32'h0033);
        chk("cred_acks",     32'(ack_cnt - ab), 32'd3);

        // ejection FIFO: fill, overflow, drain in order
        do_reset();
        cb = cred_cnt;
        for (int i = 0; i < 8; i++) push_rx(rv[i].data);
        push_rx(16'h0099);
        @(negedge clk);
        chk("rx_full_valid", 32'(bus.rx_valid_o), 32'd1);
        chk("rx_no_credit",  32'(cred_cnt - cb), 32'd0);
        chk("rx_overflow",   32'(bus.err_overflow_o), 32'd1);
        tick();
        bus.rx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rx_pop%0d", i), 32'({bus.rx_valid_o, bus.rx_head_o, bus.rx_data_o}),
                32'({1'b1, rv[i].head, rv[i].data}));
        end
        tick();
        bus.rx_ready_i = 1'b0;
        repeat (3) tick();
        chk("rx_empty",       32'(bus.rx_valid_o), 32'd0);
        chk("rx_credits",     32'(cred_cnt - cb), 32'd8);
        chk("rx_err_sticky",  32'(bus.err_overflow_o), 32'd1);

        // write and pop together while full: no overflow, newest flit kept
        do_reset();
        for (int i = 0; i < 8; i++) push_rx(16'h0030 + 16'(i));
        bus.rx_ready_i = 1'b1;
        push_rx(16'h0040);
        bus.rx_ready_i = 1'b0;
        @(negedge clk);
        chk("rw_full_err",  32'(bus.err_overflow_o), 32'd0);
        chk("rw_full_head", 32'(bus.rx_data_o), 32'h0031);
        tick();
        bus.rx_ready_i = 1'b1;
        last = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            last = bus.rx_data_o;
        end
        tick();
        bus.rx_ready_i = 1'b0;
        @(negedge clk);
        chk("rw_full_last",  32'(last), 32'h0040);
        chk("rw_full_empty", 32'(bus.rx_valid_o), 32'd0);

        // packet statistics
        do_reset();
        fb = flit_q.size();
        queue_pkt(16'h0A0A, {16'h00C1, 16'h00C2, 16'h00C3});
        queue_pkt(16'h0B0B, {16'h00D1, 16'h00D2, 16'h00D3});
        wait_flits(fb, 8, 80);
        bus.rx_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push_rx(16'h0E00 + 16'(i));
        repeat (5) tick();
        bus.rx_ready_i = 1'b0;
        chk("stat_tx", 32'(bus.stat_tx_pkts_o), 32'(EXP_STAT_TX));
        chk("stat_rx", 32'(bus.stat_rx_pkts_o), 32'(EXP_STAT_RX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
